ps2_alloc_tracker: RTL and testbench

- Dual-port entry allocator for a small structure (RS/ROB/LSQ slot pool).
- Consumes the free-entry bitmap as requests and grants up to two entries per cycle from opposite ends of the vector: port 0 scans up, port 1 scans down.
- Encodes the grants to indices and tracks busy/free state until entries are released.
- Sits between dispatch (alloc requests) and issue/retire (frees).

---
 rtl/ps2_alloc_tracker.sv | 130 +++++++++++++
 tb/tb_ps2_alloc_tracker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_alloc_tracker.sv
// rtl/ps2_alloc_tracker.sv - dual-port slot allocator (port 0 low end, port 1 high end) with busy tracking
// Optional: define ALLOC_ROTATE_EN for a round-robin search start pointer.
module ps2_alloc_tracker #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic [1:0]      alloc_req,
  input  logic [N-1:0]    free_en,
  output logic [1:0]      alloc_gnt,
  output logic [IDXW-1:0] alloc_idx0,
  output logic [IDXW-1:0] alloc_idx1,
  output logic [N-1:0]    busy,
  output logic [IDXW:0]   free_count,
  output logic            full,
  output logic            empty
);

  logic            found0;
  logic            found1;
  logic [IDXW-1:0] scan0;
  logic [IDXW-1:0] scan1;
  logic [N-1:0]    busy_next;
  logic [IDXW:0]   released;
  logic [IDXW:0]   count_next;

`ifdef ALLOC_ROTATE_EN
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_m1;

  assign ptr_m1 = ptr - IDXW'(1);

  // Port 1 walks the same ring in reverse, so it only collides with port 0 when one entry is free.
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    scan0  = '0;
    scan1  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (!busy[ptr + IDXW'(k)]) begin
        found0 = 1'b1;
        scan0  = ptr + IDXW'(k);
      end
      if (!busy[ptr_m1 - IDXW'(k)]) begin
        found1 = 1'b1;
        scan1  = ptr_m1 - IDXW'(k);
      end
    end
  end
`else
  // Last hit wins: descending loop leaves the lowest free index, ascending the highest.
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    scan0  = '0;
    scan1  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (!busy[k]) begin
        found0 = 1'b1;
        scan0  = IDXW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!busy[k]) begin
        found1 = 1'b1;
        scan1  = IDXW'(k);
      end
    end
  end
`endif

  always_comb begin
    alloc_gnt  = 2'b00;
    alloc_idx0 = '0;
    alloc_idx1 = '0;
    if (!reset) begin
      if (alloc_req[0] && found0) begin
        alloc_gnt[0] = 1'b1;
        alloc_idx0   = scan0;
      end
      if (alloc_req[1] && found1 && !(alloc_gnt[0] && (scan1 == scan0))) begin
        alloc_gnt[1] = 1'b1;
        alloc_idx1   = scan1;
      end
    end
  end

  always_comb begin
    busy_next = busy & ~free_en;
    if (alloc_gnt[0]) busy_next[alloc_idx0] = 1'b1;
    if (alloc_gnt[1]) busy_next[alloc_idx1] = 1'b1;
    released = '0;
    for (int i = 0; i < N; i++) begin
      released = released + (IDXW+1)'(free_en[i] & busy[i]);
    end
    count_next = free_count + released
               - (IDXW+1)'(alloc_gnt[0]) - (IDXW+1)'(alloc_gnt[1]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      free_count <= (IDXW+1)'(N);
    end else if (flush) begin
      busy       <= '0;
      free_count <= (IDXW+1)'(N);
    end else begin
      busy       <= busy_next;
      free_count <= count_next;
    end
  end

`ifdef ALLOC_ROTATE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (alloc_gnt[0]) begin
      ptr <= alloc_idx0 + IDXW'(1);
    end
  end
`endif

  assign full  = (free_count == '0);
  assign empty = (free_count == (IDXW+1)'(N));

endmodule

// File: tb/tb_ps2_alloc_tracker.sv
// tb/tb_ps2_alloc_tracker.sv - directed and randomized checks of ps2_alloc_tracker against a free-list model
module tb_ps2_alloc_tracker;
  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] alloc_req;
  logic [7:0] free_en;
  logic [1:0] alloc_gnt;
  logic [2:0] alloc_idx0;
  logic [2:0] alloc_idx1;
  logic [7:0] busy;
  logic [3:0] free_count;
  logic       full;
  logic       empty;

  int errors = 0;
  int checks = 0;

  bit mbusy [N];

  ps2_alloc_tracker #(.N(N)) dut (
    .clock(clock), .reset(reset), .flush(flush), .alloc_req(alloc_req),
    .free_en(free_en), .alloc_gnt(alloc_gnt), .alloc_idx0(alloc_idx0),
    .alloc_idx1(alloc_idx1), .busy(busy), .free_count(free_count),
    .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  // Model: ordered list of free slots; port 0 takes the head, port 1 the tail.
  function automatic void model_grant(input logic [1:0] req, output logic [1:0] g,
                                      output logic [2:0] i0, output logic [2:0] i1);
    int q[$];
    for (int i = 0; i < N; i++) if (!mbusy[i]) q.push_back(i);
    g = 2'b00; i0 = 3'd0; i1 = 3'd0;
    if (req[0] && q.size() > 0) begin g[0] = 1'b1; i0 = 3'(q[0]); end
    if (req[1] && (q.size() > 1 || (q.size() == 1 && !g[0]))) begin
      g[1] = 1'b1; i1 = 3'(q[q.size()-1]);
    end
  endfunction

  function automatic logic [7:0] model_vec();
    logic [7:0] v;
    for (int i = 0; i < N; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic logic [3:0] model_free();
    int c = N;
    for (int i = 0; i < N; i++) c -= int'(mbusy[i]);
    return 4'(c);
  endfunction

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; alloc_req = 2'b00; free_en = 8'h00;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; alloc_req = 2'b11; free_en = 8'h00;
    @(posedge clock); #1;
    checks++;
    if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", alloc_gnt); end
    checks++;
    if (busy !== 8'h00 || free_count !== 4'd8 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_state busy=%h cnt=%0d empty=%b full=%b exp 00/8/1/0", busy, free_count, empty, full);
    end
    alloc_req = 2'b00;
    reset = 1'b0;
    for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
  endtask

  task automatic test_fill();
    logic [2:0] e0 [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] e1 [4] = '{3'd7, 3'd6, 3'd5, 3'd4};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      alloc_req = 2'b11; #1;
      checks++;
      if (alloc_gnt !== 2'b11 || alloc_idx0 !== e0[c] || alloc_idx1 !== e1[c]) begin
        errors++; $display("FAIL fill_grant c=%0d gnt=%b i0=%0d i1=%0d exp 11/%0d/%0d", c, alloc_gnt, alloc_idx0, alloc_idx1, e0[c], e1[c]);
      end
      @(posedge clock); #1;
      if (c == 0) begin
        checks++;
        if (busy !== 8'b1000_0001 || free_count !== 4'd6) begin
          errors++; $display("FAIL fill_first busy=%b cnt=%0d exp 10000001/6", busy, free_count);
        end
      end
    end
    #1;
    checks++;
    if (full !== 1'b1 || alloc_gnt !== 2'b00 || busy !== 8'hFF) begin
      errors++; $display("FAIL fill_full full=%b gnt=%b busy=%h exp 1/00/ff", full, alloc_gnt, busy);
    end
    alloc_req = 2'b00;
  endtask

  task automatic test_free_same_cycle();
    // Pool is full from test_fill.
    free_en = 8'b0001_0000; alloc_req = 2'b01; #1;
    checks++;
    if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL free_same_gnt got=%b exp=00", alloc_gnt); end
    @(posedge clock); #1;
    free_en = 8'h00; #1;
    checks++;
    if (alloc_gnt !== 2'b01 || alloc_idx0 !== 3'd4) begin
      errors++; $display("FAIL free_next_gnt gnt=%b i0=%0d exp 01/4", alloc_gnt, alloc_idx0);
    end
    alloc_req = 2'b00;
  endtask

  task automatic test_single_free();
    do_reset();
    alloc_req = 2'b11;
    repeat (4) @(posedge clock);
    #1; alloc_req = 2'b00; free_en = 8'b0010_0000;
    @(posedge clock); #1;
    free_en = 8'h00; alloc_req = 2'b11; #1;
    checks++;
    if (alloc_gnt !== 2'b01 || alloc_idx0 !== 3'd5 || alloc_idx1 !== 3'd0) begin
      errors++; $display("FAIL single_both gnt=%b i0=%0d i1=%0d exp 01/5/0", alloc_gnt, alloc_idx0, alloc_idx1);
    end
    alloc_req = 2'b10; #1;
    checks++;
    if (alloc_gnt !== 2'b10 || alloc_idx1 !== 3'd5 || alloc_idx0 !== 3'd0) begin
      errors++; $display("FAIL single_p1 gnt=%b i1=%0d i0=%0d exp 10/5/0", alloc_gnt, alloc_idx1, alloc_idx0);
    end
    alloc_req = 2'b00;
  endtask

  task automatic test_ignore_free();
    do_reset();
    alloc_req = 2'b01;
    repeat (4) @(posedge clock);
    #1; alloc_req = 2'b00; free_en = 8'b0011_0011;
    @(posedge clock); #1;
    free_en = 8'h00;
    checks++;
    if (busy !== 8'b0000_1100 || free_count !== 4'd6) begin
      errors++; $display("FAIL ignore_free busy=%b cnt=%0d exp 00001100/6", busy, free_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 2'b11;
    repeat (4) @(posedge clock);
    #1; flush = 1'b1; #1;
    checks++;
    if (busy !== 8'hFF || alloc_gnt !== 2'b00) begin
      errors++; $display("FAIL flush_pre busy=%h gnt=%b exp ff/00", busy, alloc_gnt);
    end
    @(posedge clock); #1;
    flush = 1'b0; alloc_req = 2'b00;
    checks++;
    if (busy !== 8'h00 || free_count !== 4'd8 || empty !== 1'b1) begin
      errors++; $display("FAIL flush_post busy=%h cnt=%0d empty=%b exp 00/8/1", busy, free_count, empty);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    alloc_req = 2'b11;
    repeat (2) @(posedge clock);
    #1; alloc_req = 2'b00;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 8'h00 || free_count !== 4'd8) begin
      errors++; $display("FAIL async_reset busy=%h cnt=%0d exp 00/8", busy, free_count);
    end
    reset = 1'b0; alloc_req = 2'b11; #1;
    checks++;
    if (alloc_gnt !== 2'b11 || alloc_idx0 !== 3'd0 || alloc_idx1 !== 3'd7) begin
      errors++; $display("FAIL post_reset_gnt gnt=%b i0=%0d i1=%0d exp 11/0/7", alloc_gnt, alloc_idx0, alloc_idx1);
    end
    alloc_req = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] eg;
    logic [2:0] ei0, ei1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      alloc_req = 2'($urandom_range(0, 3));
      free_en   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      flush     = ($urandom_range(0, 40) == 0);
      #1;
      model_grant(alloc_req, eg, ei0, ei1);
      checks++;
      if (alloc_gnt !== eg || alloc_idx0 !== ei0 || alloc_idx1 !== ei1) begin
        errors++; $display("FAIL rand_grant c=%0d gnt=%b i0=%0d i1=%0d exp %b/%0d/%0d", c, alloc_gnt, alloc_idx0, alloc_idx1, eg, ei0, ei1);
      end
      if (flush) begin
        for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) if (free_en[i]) mbusy[i] = 1'b0;
        if (eg[0]) mbusy[ei0] = 1'b1;
        if (eg[1]) mbusy[ei1] = 1'b1;
      end
      @(posedge clock); #1;
      checks++;
      if (busy !== model_vec() || free_count !== model_free() ||
          full !== (model_free() == 4'd0) || empty !== (model_free() == 4'd8)) begin
        errors++; $display("FAIL rand_state c=%0d busy=%h cnt=%0d full=%b empty=%b exp %h/%0d", c, busy, free_count, full, empty, model_vec(), model_free());
      end
    end
    alloc_req = 2'b00; free_en = 8'h00; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_free_same_cycle();
    test_single_free();
    test_ignore_free();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
